fir_err_capture: RTL and testbench
==================================

Name: fir_err_capture

Overview:
- Sink-side counterpart to the stream that feeds fir_adaptive: captures the adaptive filter's error output o_err into an internal RAM of 2**NB_DEPTH words, then plays the buffer back over a valid/ready read port for offload and golden-file comparison.
- Discards the first LATENCY valid samples after arming to absorb the filter pipeline fill.
- Tracks the peak |e| over each capture window.

Parameters:
- NB_DATA, 16, sample width (signed two's complement).
- NB_DEPTH, 15, log2 of capture depth; buffer holds 2**NB_DEPTH samples.
- LATENCY, 3, number of valid samples discarded after arming before capture starts (0 allowed).

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_arm  in  1  single-cycle pulse: start a new capture.
- i_err  in  NB_DATA  signed error sample from the filter.
- i_valid  in  1  i_err is a new sample this cycle.
- i_rd_start  in  1  single-cycle pulse: begin playback of a full buffer.
- i_ready  in  1  downstream accepts o_data this cycle.
- o_data  out  NB_DATA  playback sample.
- o_valid  out  1  o_data valid.
- o_done  out  1  buffer full and unread or being read.
- o_busy  out  1  in SKIP or CAPT.
- o_peak  out  NB_DATA  max |i_err| captured in the current window (unsigned magnitude).
- o_state  out  3  FSM state: IDLE=0, SKIP=1, CAPT=2, FULL=3, READ=4.

Behaviour:
- Reset (async, any state): state=IDLE; write/read addresses, skip count, o_peak, o_data, o_valid, o_done and o_busy all 0. RAM contents are not cleared.
- IDLE:
  - i_arm -> SKIP, or -> CAPT directly if LATENCY=0.
  - skip count, write address and o_peak are cleared on the arm edge.
  - i_rd_start ignored.
- SKIP: each i_valid increments the skip count; on the LATENCY-th valid -> CAPT. Discarded samples are neither written nor included in o_peak.
- CAPT:
  - each i_valid writes i_err to RAM[wr_addr], wr_addr++, and updates o_peak.
  - the write to address 2**NB_DEPTH-1 -> FULL; o_done=1 the next cycle.
  - samples arriving with i_valid=0 are ignored.
- Peak rule: |x| = x for x>=0, -x otherwise; the most negative value (-2**(NB_DATA-1)) saturates to 2**(NB_DATA-1)-1. o_peak updates one cycle after the sample and never decreases within a window.
- FULL:
  - i_rd_start -> READ.
  - i_arm -> SKIP/CAPT as from IDLE, with o_done cleared (buffer discarded).
  - if both are asserted in the same cycle, i_arm wins.
- READ:
  - o_valid rises exactly 2 cycles after i_rd_start is sampled, with o_data=RAM[0].
  - a word transfers on o_valid & i_ready; with i_ready held high, one word per cycle, no bubbles.
  - with i_ready low, o_data and o_valid hold stable.
  - after the transfer of word 2**NB_DEPTH-1: o_valid=0, o_done=0, state -> IDLE the next cycle.
  - i_arm and i_rd_start ignored.
- o_busy = (state==SKIP or state==CAPT).
- i_err is sampled only on i_valid; no assumption on its value otherwise.
- Reset mid-CAPT or mid-READ aborts immediately; the next arm starts a fresh window at address 0.
- Address counters are NB_DEPTH bits and never wrap during capture: FULL is entered at the last address.

Test Plan (NB_DEPTH=4, LATENCY=3 unless noted):
- Basic capture/readback: arm, then i_valid every cycle with i_err = 0,1,...,18 -> values 0,1,2 skipped; o_done=1 after 16 writes; playback with i_ready=1 yields 3..18 on 16 consecutive cycles, first o_valid 2 cycles after i_rd_start; then o_state=0 and o_done=0.
- Gappy input and backpressure: i_valid every 3rd cycle; i_ready toggling 1,0,0,1 during playback -> same 16-word sequence, no loss or duplication; o_data stable while i_ready=0.
- Peak/saturation: capture a window containing -5, 7, -32768, 100 -> o_peak = 5, 7, 32767, 32767 in turn; re-arm clears o_peak to 0.
- Arm/read collision and ignores: in FULL, assert i_arm and i_rd_start together -> state=SKIP, o_done=0, no o_valid; i_rd_start in IDLE -> no change; i_arm during READ -> ignored, playback completes.
- Async reset: assert i_rst mid-CAPT (after 7 writes) between clock edges -> o_state=0, o_busy=0 and o_peak=0 immediately, without waiting for a clock edge; a subsequent arm/capture reads back only the new data from address 0.
- LATENCY=0: arm goes straight to CAPT; the first valid sample is stored at address 0 and read back as the first word.

Source files
------------

// File: rtl/fir_err_capture.sv
// Error-sample capture buffer: skips pipeline-fill samples after arming, stores one window of
// filter error samples, tracks its peak magnitude, and plays it back over a valid/ready port.
module fir_err_capture #(
    parameter int unsigned NB_DATA  = 16,
    parameter int unsigned NB_DEPTH = 15,
    parameter int unsigned LATENCY  = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_arm,
    input  logic [NB_DATA-1:0] i_err,
    input  logic               i_valid,
    input  logic               i_rd_start,
    input  logic               i_ready,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    output logic               o_done,
    output logic               o_busy,
    output logic [NB_DATA-1:0] o_peak,
    output logic [2:0]         o_state
);

    localparam int unsigned Depth = 2 ** NB_DEPTH;
    localparam int unsigned SkipW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [NB_DEPTH-1:0] LastAddr = NB_DEPTH'(Depth - 1);
    localparam logic [SkipW-1:0]    LastSkip = SkipW'(LATENCY - 1);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StSkip = 3'd1,
        StCapt = 3'd2,
        StFull = 3'd3,
        StRead = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic [NB_DATA-1:0]  mem [Depth];
    logic [NB_DEPTH-1:0] wr_addr_q;
    logic [NB_DEPTH-1:0] rd_addr_q;
    logic                rd_issued_q;
    logic [SkipW-1:0]    skip_cnt_q;
    logic [NB_DATA-1:0]  peak_q;
    logic [NB_DATA-1:0]  ram_q;
    logic                s1_valid_q;
    logic [NB_DATA-1:0]  data_q;
    logic                valid_q;

    logic               arm_go;
    logic               wr_en;
    logic               rd_adv;
    logic               rd_issue;
    logic               rd_last;
    logic [NB_DATA-1:0] err_abs;

    // Magnitude with the most negative code saturated so it still fits in NB_DATA bits.
    function automatic logic [NB_DATA-1:0] sat_abs(input logic [NB_DATA-1:0] x);
        if (!x[NB_DATA-1]) begin
            return x;
        end
        if (x == {1'b1, {(NB_DATA-1){1'b0}}}) begin
            return {1'b0, {(NB_DATA-1){1'b1}}};
        end
        return -x;
    endfunction

    assign err_abs  = sat_abs(i_err);
    assign arm_go   = i_arm && ((state_q == StIdle) || (state_q == StFull));
    assign wr_en    = (state_q == StCapt) && i_valid;
    // Two-stage read pipeline (RAM register, output register) stalls as a unit.
    assign rd_adv   = !valid_q || i_ready;
    assign rd_issue = (state_q == StRead) && !rd_issued_q && rd_adv;
    assign rd_last  = (state_q == StRead) && valid_q && i_ready && !s1_valid_q && rd_issued_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (i_arm) begin
                    if (LATENCY == 0) state_d = StCapt;
                    else              state_d = StSkip;
                end
            end
            StSkip: begin
                if (i_valid && (skip_cnt_q == LastSkip)) state_d = StCapt;
            end
            StCapt: begin
                if (i_valid && (wr_addr_q == LastAddr)) state_d = StFull;
            end
            StFull: begin
                if (i_arm) begin
                    if (LATENCY == 0) state_d = StCapt;
                    else              state_d = StSkip;
                end else if (i_rd_start) begin
                    state_d = StRead;
                end
            end
            StRead: begin
                if (rd_last) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        o_state = state_q;
        o_busy  = (state_q == StSkip) || (state_q == StCapt);
        o_done  = (state_q == StFull) || (state_q == StRead);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            rd_issued_q <= 1'b0;
            skip_cnt_q  <= '0;
            peak_q      <= '0;
            s1_valid_q  <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            if (arm_go) begin
                skip_cnt_q <= '0;
                wr_addr_q  <= '0;
                peak_q     <= '0;
            end
            if ((state_q == StSkip) && i_valid) begin
                skip_cnt_q <= skip_cnt_q + SkipW'(1);
            end
            if (wr_en) begin
                if (wr_addr_q != LastAddr) wr_addr_q <= wr_addr_q + NB_DEPTH'(1);
                if (err_abs > peak_q)      peak_q    <= err_abs;
            end
            if ((state_q == StFull) && i_rd_start && !i_arm) begin
                rd_addr_q   <= '0;
                rd_issued_q <= 1'b0;
            end
            if (rd_issue) begin
                if (rd_addr_q == LastAddr) rd_issued_q <= 1'b1;
                else                       rd_addr_q   <= rd_addr_q + NB_DEPTH'(1);
            end
            if ((state_q == StRead) && rd_adv) begin
                s1_valid_q <= rd_issue;
                valid_q    <= s1_valid_q;
                if (s1_valid_q) data_q <= ram_q;
            end
        end
    end

    // Storage has no reset so it can map onto block RAM.
    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_addr_q] <= i_err;
        if (rd_issue) ram_q <= mem[rd_addr_q];
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_peak  = peak_q;

endmodule

// File: tb/tb_fir_err_capture.sv
// Directed/randomized bench for fir_err_capture (NB_DEPTH=4) with a queue-based reference model;
// a second instance with LATENCY=0 shares the stimulus.
module tb_fir_err_capture;

    localparam int unsigned NbData = 16;
    localparam int unsigned NbDepth = 4;
    localparam int unsigned Lat = 3;
    localparam int Words = 2 ** NbDepth;

    logic              tb_clk;
    logic              i_rst, i_arm, i_valid, i_rd_start, i_ready;
    logic [NbData-1:0] i_err;
    logic [NbData-1:0] o_data, o_peak, o_data0, o_peak0;
    logic              o_valid, o_done, o_busy, o_valid0, o_done0, o_busy0;
    logic [2:0]        o_state, o_state0;

    int checks = 0;
    int errors = 0;
    logic [NbData-1:0] sent[$];

    fir_err_capture #(.NB_DATA(NbData), .NB_DEPTH(NbDepth), .LATENCY(Lat)) dut (
        .i_clk(tb_clk), .i_rst(i_rst), .i_arm(i_arm), .i_err(i_err), .i_valid(i_valid),
        .i_rd_start(i_rd_start), .i_ready(i_ready), .o_data(o_data), .o_valid(o_valid),
        .o_done(o_done), .o_busy(o_busy), .o_peak(o_peak), .o_state(o_state)
    );

    fir_err_capture #(.NB_DATA(NbData), .NB_DEPTH(NbDepth), .LATENCY(0)) dut0 (
        .i_clk(tb_clk), .i_rst(i_rst), .i_arm(i_arm), .i_err(i_err), .i_valid(i_valid),
        .i_rd_start(i_rd_start), .i_ready(i_ready), .o_data(o_data0), .o_valid(o_valid0),
        .o_done(o_done0), .o_busy(o_busy0), .o_peak(o_peak0), .o_state(o_state0)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int mag(input logic [NbData-1:0] v);
        int x;
        x = int'($signed(v));
        if (x < 0) x = -x;
        if (x > 32767) x = 32767;
        return x;
    endfunction

    // Peak over the samples that survive the skip, i.e. the ones that were captured.
    function automatic int model_peak();
        int p;
        p = 0;
        for (int i = Lat; i < sent.size() && i < Lat + Words; i++) begin
            if (mag(sent[i]) > p) p = mag(sent[i]);
        end
        return p;
    endfunction

    task automatic arm();
        i_arm = 1'b1;
        tick();
        i_arm = 1'b0;
        sent.delete();
    endtask

    task automatic feed(input logic [NbData-1:0] v, input int gap);
        i_valid = 1'b1;
        i_err   = v;
        tick();
        sent.push_back(v);
        i_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            i_err = NbData'($urandom);
            tick();
        end
    endtask

    // mode 0: ready always high, 1: ready pattern 1,0,0,1, 2: random ready.
    task automatic readback(input int mode, input int arm_at);
        int idx, cyc;
        bit held;
        logic [NbData-1:0] held_data;
        idx = 0;
        cyc = 0;
        held = 0;
        held_data = '0;
        i_ready = 1'b1;
        i_rd_start = 1'b1;
        tick();
        i_rd_start = 1'b0;
        check("rd_lat0_valid", o_valid, 0);
        tick();
        check("rd_lat1_valid", o_valid, 0);
        tick();
        check("rd_first_valid", o_valid, 1);
        check("rd_first_data", o_data, sent[Lat]);
        while (idx < Words && cyc < 100) begin
            case (mode)
                0:       i_ready = 1'b1;
                1:       i_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: i_ready = 1'($urandom_range(0, 1));
            endcase
            i_arm = (cyc == arm_at);
            check("rd_valid", o_valid, 1);
            if (held) check("rd_hold", o_data, held_data);
            if (i_ready) begin
                check("rd_data", o_data, sent[Lat + idx]);
                idx++;
                held = 0;
            end else begin
                held = 1;
                held_data = o_data;
            end
            tick();
            cyc++;
        end
        i_arm = 1'b0;
        i_ready = 1'b0;
        check("rd_count", idx, Words);
        check("rd_end_valid", o_valid, 0);
        check("rd_end_done", o_done, 0);
        check("rd_end_state", o_state, 0);
    endtask

    initial begin
        logic [NbData-1:0] v0 [Words];
        i_rst = 1'b1;
        i_arm = 1'b0;
        i_valid = 1'b0;
        i_rd_start = 1'b0;
        i_ready = 1'b0;
        i_err = '0;
        tick();
        tick();
        check("rst_state", o_state, 0);
        check("rst_valid", o_valid, 0);
        check("rst_done", o_done, 0);
        check("rst_busy", o_busy, 0);
        check("rst_peak", o_peak, 0);
        check("rst_data", o_data, 0);
        i_rst = 1'b0;
        tick();

        // Basic capture and readback.
        arm();
        check("arm_state", o_state, 1);
        check("arm_busy", o_busy, 1);
        for (int v = 0; v < 18; v++) feed(NbData'(v), 0);
        check("pre_full_state", o_state, 2);
        check("pre_full_done", o_done, 0);
        feed(NbData'(18), 0);
        check("full_state", o_state, 3);
        check("full_done", o_done, 1);
        check("full_busy", o_busy, 0);
        check("full_peak", o_peak, model_peak());
        readback(0, -1);

        // Read start in idle is ignored.
        i_rd_start = 1'b1;
        tick();
        i_rd_start = 1'b0;
        tick();
        tick();
        check("idle_rd_state", o_state, 0);
        check("idle_rd_valid", o_valid, 0);

        // Gappy input, backpressure, arm during playback.
        arm();
        for (int k = 0; k < Lat + Words; k++) feed(NbData'($urandom), 2);
        check("gap_full_done", o_done, 1);
        check("gap_peak", o_peak, model_peak());
        readback(1, 5);

        // Peak tracking with saturation.
        arm();
        for (int k = 0; k < Lat; k++) feed(NbData'($urandom), 0);
        check("skip_peak", o_peak, 0);
        feed(-16'sd5, 0);
        check("peak_a", o_peak, model_peak());
        feed(16'sd7, 0);
        check("peak_b", o_peak, model_peak());
        feed(16'h8000, 0);
        check("peak_sat", o_peak, model_peak());
        feed(16'sd100, 0);
        check("peak_hold", o_peak, 32767);
        for (int k = 0; k < Words - 4; k++) begin
            feed(NbData'($urandom_range(0, 2000)), $urandom_range(0, 1));
            check("peak_run", o_peak, model_peak());
        end
        check("peak_full", o_state, 3);

        // Arm and read start together: arm wins.
        i_arm = 1'b1;
        i_rd_start = 1'b1;
        tick();
        i_arm = 1'b0;
        i_rd_start = 1'b0;
        sent.delete();
        check("coll_state", o_state, 1);
        check("coll_done", o_done, 0);
        check("coll_peak", o_peak, 0);
        tick();
        tick();
        tick();
        check("coll_valid", o_valid, 0);

        // Asynchronous reset mid-capture.
        for (int k = 0; k < Lat + 7; k++) feed(NbData'($urandom_range(1, 30000)), 0);
        check("pre_rst_peak", o_peak, model_peak());
        #2;
        i_rst = 1'b1;
        #1;
        check("arst_state", o_state, 0);
        check("arst_busy", o_busy, 0);
        check("arst_peak", o_peak, 0);
        @(posedge tb_clk);
        #1;
        i_rst = 1'b0;
        tick();
        arm();
        for (int k = 0; k < Lat + Words; k++) feed(NbData'($urandom), $urandom_range(0, 2));
        check("post_rst_done", o_done, 1);
        readback(2, -1);

        // LATENCY=0 instance: first valid sample lands at address 0.
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        tick();
        i_arm = 1'b1;
        tick();
        i_arm = 1'b0;
        check("l0_arm_state", o_state0, 2);
        for (int k = 0; k < Words; k++) begin
            v0[k] = NbData'($urandom);
            i_valid = 1'b1;
            i_err = v0[k];
            tick();
        end
        i_valid = 1'b0;
        check("l0_full_state", o_state0, 3);
        check("l0_full_done", o_done0, 1);
        i_ready = 1'b1;
        i_rd_start = 1'b1;
        tick();
        i_rd_start = 1'b0;
        tick();
        check("l0_lat_valid", o_valid0, 0);
        tick();
        for (int k = 0; k < Words; k++) begin
            check("l0_valid", o_valid0, 1);
            check("l0_data", o_data0, v0[k]);
            tick();
        end
        check("l0_end_valid", o_valid0, 0);
        check("l0_end_state", o_state0, 0);
        i_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
